ex_mem: RTL and testbench

- Pipeline register between the EX stage and the MEM stage of the 5-stage MIPS core.
- Captures the EX results each cycle: register write-back data/address/enable, HI/LO values and HI/LO write enable.
- Honours the global stall vector. Inserts a bubble into MEM when EX is stalled but MEM is not.
- Carries the two-cycle MADD/MSUB accumulator state (hilo_temp, cnt) back to EX while EX is stalled.

---
 rtl/ex_mem.sv | 84 ++++++++
 tb/tb_ex_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures EX results, inserts bubbles on EX stall,
// and returns the MADD/MSUB accumulator state to EX while EX is held.
module ex_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            stall,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [ADDR_W-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_whilo,
  input  logic [2*DATA_W-1:0]   hilo_temp_i,
  input  logic [CNT_W-1:0]      cnt_i,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [ADDR_W-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_whilo,
  output logic                  mem_valid,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [CNT_W-1:0]      cnt_o
);

  localparam int unsigned HILO_W = 2 * DATA_W;

  logic load;
  logic bubble;
  logic unused_stall;

  // EX advancing always loads; an illegal MEM-only stall is treated the same way.
  assign load         = ~stall[3];
  assign bubble       = stall[3] & ~stall[4];
  assign unused_stall = ^{stall[5], stall[2:0]};

  // Write-back payload towards MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wdata <= '0;
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
    end else if (load) begin
      mem_wdata <= ex_wdata;
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo;
      mem_valid <= 1'b1;
    end else if (bubble) begin
      mem_wdata <= '0;
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      mem_valid <= 1'b0;
    end
  end

  // Accumulator state loops back to EX only while EX is stalled behind a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hilo_temp_o <= HILO_W'(0);
      cnt_o       <= CNT_W'(0);
    end else if (load) begin
      hilo_temp_o <= HILO_W'(0);
      cnt_o       <= CNT_W'(0);
    end else if (bubble) begin
      hilo_temp_o <= hilo_temp_i;
      cnt_o       <= cnt_i;
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed steps plus randomized stall/data
// traffic compared against a rule-level reference model.
module tb_ex_mem;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [5:0]          stall = '0;
  logic [DATA_W-1:0]   ex_wdata = '0;
  logic [ADDR_W-1:0]   ex_wd = '0;
  logic                ex_wreg = 1'b0;
  logic [DATA_W-1:0]   ex_hi = '0;
  logic [DATA_W-1:0]   ex_lo = '0;
  logic                ex_whilo = 1'b0;
  logic [2*DATA_W-1:0] hilo_temp_i = '0;
  logic [CNT_W-1:0]    cnt_i = '0;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   mem_wd;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_whilo;
  logic                mem_valid;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [CNT_W-1:0]    cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs
  logic [DATA_W-1:0]   e_wdata, e_hi, e_lo;
  logic [ADDR_W-1:0]   e_wd;
  logic                e_wreg, e_whilo, e_valid;
  logic [2*DATA_W-1:0] e_hilo;
  logic [CNT_W-1:0]    e_cnt;

  always #5 clk = ~clk;

  ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_valid(mem_valid), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  task automatic model_reset();
    e_wdata = '0; e_wd = '0; e_wreg = 1'b0; e_hi = '0; e_lo = '0;
    e_whilo = 1'b0; e_valid = 1'b0; e_hilo = '0; e_cnt = '0;
  endtask

  // One clock edge of the pipeline register, by its stage rules.
  task automatic model_edge(input logic [5:0] s);
    bit ex_stalled  = s[3];
    bit mem_stalled = s[4];
    if (!ex_stalled) begin
      e_wdata = ex_wdata; e_wd = ex_wd; e_wreg = ex_wreg;
      e_hi = ex_hi; e_lo = ex_lo; e_whilo = ex_whilo; e_valid = 1'b1;
      e_hilo = '0; e_cnt = '0;
    end else if (!mem_stalled) begin
      e_wdata = '0; e_wd = '0; e_wreg = 1'b0; e_hi = '0; e_lo = '0;
      e_whilo = 1'b0; e_valid = 1'b0;
      e_hilo = hilo_temp_i; e_cnt = cnt_i;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'(e_wdata));
    chk({tag, ".wd"},    64'(mem_wd),    64'(e_wd));
    chk({tag, ".wreg"},  64'(mem_wreg),  64'(e_wreg));
    chk({tag, ".hi"},    64'(mem_hi),    64'(e_hi));
    chk({tag, ".lo"},    64'(mem_lo),    64'(e_lo));
    chk({tag, ".whilo"}, 64'(mem_whilo), 64'(e_whilo));
    chk({tag, ".valid"}, 64'(mem_valid), 64'(e_valid));
    chk({tag, ".hilo"},  hilo_temp_o,    e_hilo);
    chk({tag, ".cnt"},   64'(cnt_o),     64'(e_cnt));
  endtask

  task automatic rand_in();
    ex_wdata    = $urandom;
    ex_wd       = ADDR_W'($urandom);
    ex_wreg     = 1'($urandom);
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_whilo    = 1'($urandom);
    hilo_temp_i = {$urandom, $urandom};
    cnt_i       = CNT_W'($urandom);
  endtask

  task automatic cycle(input logic [5:0] s, input string tag);
    stall = s;
    @(posedge clk);
    model_edge(s);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [5:0] s;
    model_reset();

    // Reset with busy inputs clears everything without an edge
    rand_in();
    #1 rst_n = 1'b0;
    #1 check_all("reset_async");
    repeat (2) @(posedge clk);
    #1 check_all("reset_held");
    @(negedge clk) rst_n = 1'b1;
    cycle(6'b000000, "reset_first_load");

    // Normal pass
    ex_wdata = 32'h12345678; ex_wd = 5'd5; ex_wreg = 1'b1;
    ex_hi = 32'hAAAA0000; ex_lo = 32'h0000BBBB; ex_whilo = 1'b1;
    cycle(6'b000000, "normal");

    // MADD bubble and consumption of the accumulator
    rand_in();
    hilo_temp_i = 64'h0000_0001_FFFF_FFFF; cnt_i = 2'd1;
    cycle(6'b001111, "madd_bubble");
    chk("madd_bubble.hilo_const", hilo_temp_o, 64'h0000_0001_FFFF_FFFF);
    rand_in();
    cycle(6'b001111, "madd_bubble2");
    rand_in();
    cycle(6'b000000, "madd_resume");
    chk("madd_resume.cnt_const", 64'(cnt_o), 64'd0);

    // Hold keeps outputs while inputs move
    rand_in();
    ex_wdata = 32'hDEADBEEF;
    cycle(6'b000000, "hold_load");
    for (int i = 0; i < 3; i++) begin
      rand_in();
      cycle(6'b011111, "hold");
      chk("hold.wdata_const", 64'(mem_wdata), 64'hDEADBEEF);
    end
    cycle(6'b000000, "hold_release");

    // Reset between edges while holding
    rand_in();
    cycle(6'b011111, "pre_reset_hold");
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("reset_mid_hold");
    #1 rst_n = 1'b1;
    rand_in();
    cycle(6'b001111, "post_reset_bubble");

    // Don't-care stall bits
    rand_in();
    cycle(6'b100111, "irrelevant_bits");

    // Randomized traffic restricted to legal stall vectors
    for (int i = 0; i < 300; i++) begin
      s = 6'($urandom);
      if (!s[3]) s[4] = 1'b0;
      rand_in();
      cycle(s, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
